mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width of the shared RAM and of all data ports.
REQ-002 Parameter ADDR_WIDTH, default 9: word-address width of the shared RAM.
REQ-003 Port list, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch port read request.
- if_addr  in  ADDR_WIDTH  fetch port read address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_WIDTH  fetch read data.
- dm_req  in  1  data port request.
- dm_we  in  1  data port write (1) or read (0).
- dm_addr  in  ADDR_WIDTH  data port address.
- dm_wdata  in  DATA_WIDTH  data port write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data read data valid.
- dm_rdata  out  DATA_WIDTH  data read data.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_WIDTH  RAM read data, valid one cycle after its address is presented.

Function
REQ-004 The block SHALL arbitrate the single-port synchronous RAM between the fetch port (read-only) and the data port (read/write), accepting at most one access per cycle.
REQ-005 Grants SHALL be combinational in the request cycle: a requester is granted in the cycle its req is high and arbitration selects it; the RAM captures the access at the following rising edge.
REQ-006 Only one of if_gnt, dm_gnt SHALL be high in any cycle; gnt SHALL be 0 whenever the matching req is 0.
REQ-007 If exactly one req is high, that port SHALL be granted.
REQ-008 If both reqs are high, the port NOT granted most recently SHALL be granted (round-robin); a 1-bit last_grant register SHALL update on every grant.
REQ-009 mem_addr, mem_data, mem_we SHALL reflect the granted port; mem_we = dm_gnt AND dm_we; with no grant, mem_addr = if_addr, mem_data = dm_wdata, mem_we = 0.
REQ-010 A requester not granted SHALL hold req, addr, we, wdata stable until granted; the block SHALL NOT latch ungranted requests.
REQ-011 Read latency SHALL be exactly one cycle: a read granted in cycle N yields rvalid = 1 on the owning port in cycle N+1, with rdata = mem_q in that cycle.
REQ-012 A 2-bit registered tag (valid, owner) SHALL track the outstanding read; writes SHALL set no tag and produce no rvalid.
REQ-013 Back-to-back accesses SHALL be supported at one per cycle with no bubble; a granted read in cycle N+1 does not suppress rvalid for cycle N's read.
REQ-014 if_rdata and dm_rdata SHALL both be driven by mem_q at all times; contents are meaningful only when the matching rvalid is 1.
REQ-015 Read of an address written by a data-port write granted the previous cycle SHALL return the newly written value (RAM write-then-read ordering).
REQ-016 if_rvalid and dm_rvalid SHALL never be high in the same cycle.

Reset
REQ-017 While rst_n = 0: if_gnt, dm_gnt, mem_we, if_rvalid, dm_rvalid SHALL all be 0 regardless of inputs.
REQ-018 Reset SHALL clear the read tag (pending rvalid discarded, not delivered after release) and set last_grant to data port, so the fetch port wins the first contest.
REQ-019 Assertion SHALL take effect immediately (asynchronous); the first grant SHALL be possible in the first cycle with rst_n = 1.

Verification
REQ-020 Single fetch: if_req=1, if_addr=0x005, RAM[5]=0x1234 -> if_gnt=1 cycle N; if_rvalid=1, if_rdata=0x1234 cycle N+1; dm_rvalid=0.
REQ-021 Contention: both req held high 4 cycles after reset -> grant order if, dm, if, dm; rvalid alternates one cycle later.
REQ-022 Write then read: dm write addr 0x1FF data 0xBEEF cycle N (mem_we=1, no rvalid), dm read 0x1FF cycle N+1 -> dm_rvalid=1, dm_rdata=0xBEEF cycle N+2.
REQ-023 Back-to-back fetch: if_req=1 for addrs 0,1,2 on consecutive cycles -> if_rvalid high 3 consecutive cycles returning RAM[0..2] in order.
REQ-024 Reset mid-read: fetch granted cycle N, rst_n=0 asserted before edge N+1 -> if_rvalid=0 in N+1 and after release; next contest grants fetch first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of request, response and RAM-side signals for the shared-RAM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment around it: the fetch/data requesters and the RAM itself.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);

  // fetch port (read-only)
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  // data port (read/write)
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  // single-port synchronous RAM
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_q,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_data, mem_we
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_q,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a
// read-only fetch port and a read/write data port.
//
// Grants are combinational in the request cycle, so the RAM captures the
// access at the next rising edge. A read returns exactly one cycle later.
// Ungranted requests are never stored: the requester holds its request until
// it is granted. A 2-bit tag (valid, owner) records which port owns the read
// whose data appears on mem_q in the following cycle.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  // Port that won most recently. Reset to PORT_DM so that fetch wins the
  // first contest after reset.
  port_e last_grant_q, last_grant_d;

  // Outstanding-read tag. It is only ever one read deep, because each read
  // completes in the cycle directly after its grant.
  logic  tag_valid_q, tag_valid_d;
  port_e tag_owner_q, tag_owner_d;

  logic                  if_gnt;
  logic                  dm_gnt;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] rdata;

  // Grant selection: a lone requester wins; on contention the port not granted
  // last wins. Nothing is granted while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n) begin
      if (bus.if_req && bus.dm_req) begin
        if (last_grant_q == PORT_DM) begin
          if_gnt = 1'b1;
        end else begin
          dm_gnt = 1'b1;
        end
      end else begin
        if_gnt = bus.if_req;
        dm_gnt = bus.dm_req;
      end
    end
  end

  // Next-state values for the round-robin pointer and the read tag.
  always_comb begin
    last_grant_d = last_grant_q;
    if (if_gnt) begin
      last_grant_d = PORT_IF;
    end else if (dm_gnt) begin
      last_grant_d = PORT_DM;
    end
    tag_valid_d = if_gnt | (dm_gnt & ~bus.dm_we);
    tag_owner_d = dm_gnt ? PORT_DM : PORT_IF;
  end

  // State registers. An asynchronous reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_DM;
      tag_valid_q  <= 1'b0;
      tag_owner_q  <= PORT_IF;
    end else begin
      last_grant_q <= last_grant_d;
      tag_valid_q  <= tag_valid_d;
      tag_owner_q  <= tag_owner_d;
    end
  end

  // RAM request path. When nothing is granted, the address defaults to fetch.
  assign addr_sel     = dm_gnt ? bus.dm_addr : bus.if_addr;
  assign bus.mem_addr = addr_sel;
  assign bus.mem_data = bus.dm_wdata;
  assign bus.mem_we   = dm_gnt & bus.dm_we;

  assign bus.if_gnt   = if_gnt;
  assign bus.dm_gnt   = dm_gnt;

  // Read return path. Both ports always see the RAM output; rvalid marks the owner.
  assign rdata         = bus.mem_q;
  assign bus.if_rdata  = rdata;
  assign bus.dm_rdata  = rdata;
  assign bus.if_rvalid = tag_valid_q && (tag_owner_q == PORT_IF);
  assign bus.dm_rvalid = tag_valid_q && (tag_owner_q == PORT_DM);

  // Structural invariants of the arbiter.
  a_gnt_onehot : assert property (@(posedge clk) !(bus.if_gnt && bus.dm_gnt));
  a_rvalid_excl : assert property (@(posedge clk) !(bus.if_rvalid && bus.dm_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter, built around a scoreboard.
// The driver issues one request cycle at a time. It checks the combinational
// grants and RAM controls against a reference model. For each read granted, it
// pushes the expected (cycle, port, data) onto a queue. A separate monitor pops
// that queue whenever the DUT raises an rvalid, and flags any rvalid that is
// missing, extra or late.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Contents of a RAM word that has never been written.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {7'h2A, a} ^ 16'hC3A5;
  endfunction

  // Behavioural synchronous RAM: mem_q carries the word addressed in the previous cycle.
  logic [DW-1:0] ram    [512];
  bit            ram_wr [512];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr]    <= bus.mem_data;
      ram_wr[bus.mem_addr] <= 1'b1;
    end
    bus.mem_q <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
  end

  // Reference model: the expected memory image, and which port was granted last (0 = fetch, 1 = data).
  logic [DW-1:0] model_mem [512];
  bit            model_last;

  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One request cycle: drive the inputs, check grants and RAM controls, then update the model.
  task automatic drive_cycle(input bit ir, input logic [AW-1:0] ia,
                             input bit dr, input bit dwe, input logic [AW-1:0] da,
                             input logic [DW-1:0] dd, output bit gi, output bit gd);
    bit ei, ed;
    @(posedge clk);
    #1;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dwe;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
    #1;
    if (!rst_n) begin
      ei = 1'b0;
      ed = 1'b0;
    end else if (ir && dr) begin
      ei = (model_last == 1'b1);
      ed = !ei;
    end else begin
      ei = ir;
      ed = dr;
    end
    check_val("if_gnt", 32'(bus.if_gnt), 32'(ei));
    check_val("dm_gnt", 32'(bus.dm_gnt), 32'(ed));
    check_val("mem_we", 32'(bus.mem_we), 32'(ed && dwe));
    check_val("mem_addr", 32'(bus.mem_addr), 32'(ed ? da : ia));
    check_val("mem_data", 32'(bus.mem_data), 32'(dd));
    if (ei) begin
      model_last = 1'b0;
      sbq.push_back('{due: cyc + 1, port: 1'b0, data: model_mem[ia]});
    end
    if (ed) begin
      model_last = 1'b1;
      if (dwe) model_mem[da] = dd;
      else     sbq.push_back('{due: cyc + 1, port: 1'b1, data: model_mem[da]});
    end
    gi = ei;
    gd = ed;
  endtask

  // Monitor: compares every read response against the scoreboard, in the middle of each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_val("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check_val("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
      end else if (bus.if_rvalid || bus.dm_rvalid) begin
        check_val("rvalid_excl", 32'(bus.if_rvalid && bus.dm_rvalid), 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rv_extra: got rvalid if=%0d dm=%0d expected none (cycle %0d)",
                   bus.if_rvalid, bus.dm_rvalid, cyc);
        end else begin
          e = sbq.pop_front();
          check_val("rv_cycle", 32'(cyc), 32'(e.due));
          check_val("rv_port", 32'(bus.dm_rvalid), 32'(e.port));
          check_val("rv_data", 32'(e.port ? bus.dm_rdata : bus.if_rdata), 32'(e.data));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        failures++;
        $display("FAIL rv_missing: got no rvalid expected port %0d data %0h (cycle %0d)",
                 e.port, e.data, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit gi, gd, pi, pd, dwe;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dd;
    logic [3:0] contend_pat;
    for (int i = 0; i < 512; i++) model_mem[i] = init_val(9'(i));
    model_last = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0;
    bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // While reset is asserted, active requests must not be granted.
    for (int i = 0; i < 3; i++) drive_cycle(1, 9'h003, 1, 1, 9'h004, 16'hAAAA, gi, gd);
    @(negedge clk);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    rst_n = 1'b1;

    // Contention from the first cycle after reset: expected order is if, dm, if, dm.
    contend_pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 9'h010, 1, 0, 9'h020, 16'h0, gi, gd);
      check_val("contend_order", 32'(gi), 32'(contend_pat[i]));
    end

    // A write followed immediately by a read of the same top address.
    drive_cycle(0, 9'h000, 1, 1, 9'h1FF, 16'hBEEF, gi, gd);
    drive_cycle(0, 9'h000, 1, 0, 9'h1FF, 16'h0, gi, gd);

    // Single fetch of address 5, after storing 0x1234 there.
    drive_cycle(0, 9'h000, 1, 1, 9'h005, 16'h1234, gi, gd);
    drive_cycle(1, 9'h005, 0, 0, 9'h000, 16'h0, gi, gd);

    // Back-to-back fetches from addresses 0, 1, 2.
    for (int i = 0; i < 3; i++) drive_cycle(1, 9'(i), 0, 0, 9'h000, 16'h0, gi, gd);

    // Randomized traffic. A pending request is held stable until it is granted.
    pi = 0; pd = 0; ia = '0; da = '0; dwe = 0; dd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pi && $urandom_range(0, 3) != 0) begin
        pi = 1;
        ia = 9'($urandom_range(0, 15));
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd  = 1;
        dwe = 1'($urandom_range(0, 1));
        da  = 9'($urandom_range(0, 15));
        dd  = 16'($urandom);
      end
      drive_cycle(pi, ia, pd, dwe, da, dd, gi, gd);
      if (gi) pi = 0;
      if (gd) pd = 0;
    end

    // Fetch is granted, then reset asserts before the next edge: its read is discarded.
    drive_cycle(0, 9'h000, 1, 0, 9'h007, 16'h0, gi, gd);
    drive_cycle(1, 9'h006, 0, 0, 9'h000, 16'h0, gi, gd);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    model_last = 1'b1;
    for (int i = 0; i < 2; i++) drive_cycle(1, 9'h006, 1, 0, 9'h007, 16'h0, gi, gd);
    @(negedge clk);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    rst_n = 1'b1;
    drive_cycle(0, 9'h000, 0, 0, 9'h000, 16'h0, gi, gd);
    drive_cycle(1, 9'h00A, 1, 0, 9'h00B, 16'h0, gi, gd);
    check_val("post_reset_first", 32'(gi), 32'd1);
    drive_cycle(1, 9'h00A, 1, 0, 9'h00B, 16'h0, gi, gd);

    // Let the remaining reads drain.
    for (int i = 0; i < 3; i++) drive_cycle(0, 9'h000, 0, 0, 9'h000, 16'h0, gi, gd);
    @(negedge clk);
    check_val("sb_drain", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
